ram_dp_be: RTL
==============

Name: ram_dp_be

Overview:
- Single-clock simple dual-port RAM: one write port and one read port.
- Adds byte-lane write enables, a selectable read latency, and a selectable read-during-write policy.
- Includes a post-reset clear engine that zeroes every location.
- Successor to the team's dual-clock simple RAM, for datapaths that run on one clock and need deterministic memory contents after reset.

Parameters:
- D_WIDTH, 16, data width in bits; must be a multiple of 8.
- A_WIDTH, 5, address width; DEPTH = 2**A_WIDTH words.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (write-through).
- CLEAR_ON_RESET, 1, when 1 the clear engine zeroes all words after reset; when 0 the contents are untouched.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- write_enable  input  1  write request.
- address_write  input  A_WIDTH  write address.
- data_write  input  D_WIDTH  write data.
- byte_enable  input  D_WIDTH/8  per-byte write mask; bit i covers data bits [8i+7:8i].
- read_enable  input  1  read request.
- address_read  input  A_WIDTH  read address.
- data_read  output  D_WIDTH  registered read data.
- read_valid  output  1  one-cycle pulse marking new data on data_read.
- busy  output  1  high while the clear engine runs; all requests are ignored.

Behaviour:
- Reset (rst_n low at a rising edge):
  - data_read=0, read_valid=0, read pipeline flushed.
  - Clear counter=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
  - busy = CLEAR_ON_RESET in the first cycle after reset.
- FSM states:
  - CLEAR: each cycle writes 0 to the word at the counter address, then increments the counter.
    - After writing DEPTH-1, the next state is IDLE.
    - busy is high for exactly DEPTH cycles after reset releases.
  - IDLE: normal operation.
  - Reset asserted mid-clear restarts the clear at address 0.
- While busy:
  - write_enable and read_enable are ignored.
  - read_valid stays 0 and data_read holds its value.
- Write (IDLE, write_enable=1 at edge N):
  - Each lane with byte_enable[i]=1 takes data_write's byte i.
  - Other lanes keep their old contents.
  - byte_enable=0 means no change.
- Read (IDLE, read_enable=1 at edge N):
  - address_read is sampled at edge N.
  - The data appears on data_read after edge N+RD_LATENCY-1, with read_valid high for that one cycle.
  - RD_LATENCY=1: registered at edge N.
  - RD_LATENCY=2: one extra output register stage.
  - Back-to-back reads are fully pipelined: one result per cycle, in request order.
- data_read holds its last value when no read completes; read_valid=0 in those cycles.
- Read-during-write, same edge, same address:
  - RDW_MODE=0: returns the contents before the write.
  - RDW_MODE=1: returns the merged word (new bytes where byte_enable=1, old bytes elsewhere).
  - Different addresses never interact.
- Addresses span the full 2**A_WIDTH range; there are no out-of-range cases.
- A write at edge N is visible to any read sampled at edge N+1 or later, regardless of RDW_MODE.
- A read in flight when busy rises (only possible through reset) is discarded by the pipeline flush.
- Storage is a plain register array with no reset, except through the clear engine.

Test Plan:
- Reset clear: defaults, rst_n low 2 cycles then high → busy high for exactly 32 cycles, then low. Reading addresses 0, 5 and 31 returns 0x0000 with read_valid one cycle after each request.
- Byte-lane write: write 0xABCD with byte_enable=2'b11 at addr 3, then 0x12FF with byte_enable=2'b01 → read addr 3 returns 0xABFF. Then byte_enable=2'b00 with data 0x0000 → still 0xABFF.
- Read-during-write: addr 7 holds 0x1111. Same edge: write 0x2222 (be=2'b11) and read addr 7. RDW_MODE=0 returns 0x1111; RDW_MODE=1 returns 0x2222. The next read of addr 7 returns 0x2222 in both modes.
- Latency/pipelining: RD_LATENCY=2, addrs 0..3 preloaded with 0xA0..0xA3, read_enable held 4 consecutive cycles → read_valid high 4 consecutive cycles, starting 2 edges after the first request, data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Requests while busy: during CLEAR, drive write_enable (addr 31, 0xFFFF) and read_enable → no read_valid pulse. After busy falls, addr 31 reads 0x0000.
- Reset mid-clear: assert rst_n low at clear cycle 10 for 1 cycle → busy stays high for 32 full cycles after release. All words read 0. data_read=0 and read_valid=0 immediately after the reset edge.

Source files
------------

// File: rtl/ram_dp_be.sv
// ---------------------------------------------------------------------------
// ram_dp_be
// Single-clock simple dual-port RAM (one write port, one read port) with
// byte-lane write enables, a selectable read latency (1 or 2 cycles), a
// selectable same-address read-during-write policy and a post-reset clear
// engine that zeroes every word before normal traffic is accepted.
//
// Ports:
//   clk           - single clock, all logic on its rising edge
//   rst_n         - synchronous active-low reset
//   write_enable  - write request
//   address_write - write address
//   data_write    - write data
//   byte_enable   - per-byte write mask, bit i covers data bits [8i+7:8i]
//   read_enable   - read request
//   address_read  - read address
//   data_read     - registered read data, holds when no read completes
//   read_valid    - one-cycle pulse marking new data on data_read
//   busy          - high while the clear engine runs; requests are ignored
// ---------------------------------------------------------------------------
module ram_dp_be #(
    parameter int D_WIDTH        = 16,
    parameter int A_WIDTH        = 5,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write_enable,
    input  logic [A_WIDTH-1:0]   address_write,
    input  logic [D_WIDTH-1:0]   data_write,
    input  logic [D_WIDTH/8-1:0] byte_enable,
    input  logic                 read_enable,
    input  logic [A_WIDTH-1:0]   address_read,
    output logic [D_WIDTH-1:0]   data_read,
    output logic                 read_valid,
    output logic                 busy
);

    localparam int DEPTH   = 2 ** A_WIDTH;
    localparam int N_BYTES = D_WIDTH / 8;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [A_WIDTH-1:0] clr_cnt;
    logic               write_fire;
    logic               read_fire;
    logic [D_WIDTH-1:0] merged_word;
    logic [D_WIDTH-1:0] read_word;

    logic [D_WIDTH-1:0] mem [DEPTH];

    // State register and clear counter. The counter is A_WIDTH wide, so it
    // wraps back to zero on the same edge the engine leaves CLEAR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Next-state logic: CLEAR lasts exactly DEPTH cycles, one word per cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (&clr_cnt) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign write_fire = write_enable && !busy;
    assign read_fire  = read_enable && !busy;

    // Byte-lane merge of the incoming write with the word it overwrites.
    // The same merged word feeds the write-through read path.
    always_comb begin
        merged_word = mem[address_write];
        for (int i = 0; i < N_BYTES; i++) begin
            if (byte_enable[i]) begin
                merged_word[8*i +: 8] = data_write[8*i +: 8];
            end
        end
    end

    // Read source: the array gives old data for a colliding write; the
    // write-through policy substitutes the merged word on an address match.
    always_comb begin
        read_word = mem[address_read];
        if ((RDW_MODE != 0) && write_fire && (address_write == address_read)) begin
            read_word = merged_word;
        end
    end

    // Storage has no reset of its own; only the clear engine zeroes it.
    // Requests presented while rst_n is low are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && busy) begin
            mem[clr_cnt] <= '0;
        end else if (rst_n && write_fire) begin
            mem[address_write] <= merged_word;
        end
    end

    // Read pipeline. With two cycles of latency an extra register stage
    // sits between the array read and the output; both stages are flushed
    // by reset so no in-flight read survives into the clear phase.
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic               s1_valid;
            logic [D_WIDTH-1:0] s1_data;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid   <= 1'b0;
                    s1_data    <= '0;
                    read_valid <= 1'b0;
                    data_read  <= '0;
                end else begin
                    s1_valid <= read_fire;
                    if (read_fire) begin
                        s1_data <= read_word;
                    end
                    read_valid <= s1_valid;
                    if (s1_valid) begin
                        data_read <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    read_valid <= 1'b0;
                    data_read  <= '0;
                end else begin
                    read_valid <= read_fire;
                    if (read_fire) begin
                        data_read <= read_word;
                    end
                end
            end
        end
    endgenerate

endmodule
